// File: rtl/lane_color_pkg.sv
// Shared types and colour constants for the lane colour mapper.
package lane_color_pkg;

    typedef enum logic [2:0] {
        L_GRAD     = 3'd0,
        L_BG       = 3'd1,
        L_RBG      = 3'd2,
        L_RECEPTOR = 3'd3,
        L_ARROW    = 3'd4,
        L_BALL     = 3'd5
    } layer_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Lane palette: red, blue, green, yellow; lanes past 3 wrap back to entry 0.
    localparam rgb_t LANE_PAL [4] = '{
        '{8'h55, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hAA},
        '{8'h00, 8'hAA, 8'h00},
        '{8'hAA, 8'hAA, 8'h00}
    };

    localparam logic [7:0] RBG_GRAY  = 8'h55;
    localparam rgb_t       GRAD_BASE = '{8'h05, 8'h4B, 8'h7F};

endpackage

// File: rtl/lane_flash_timer.sv
// One lane's hit-flash counter: a hit reloads it, frame starts count it down to zero.
module lane_flash_timer #(
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hit_i,
    input  logic       frame_start_i,
    output logic [3:0] cnt_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: a hit wins over a same-cycle frame start.
    always_comb begin
        cnt_d = cnt_q;
        if (hit_i) begin
            cnt_d = 4'(FLASH_FRAMES);
        end else if (frame_start_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lane_color_mapper.sv
// Two-stage layer-priority resolver and palette/flash colour mapper driving registered VGA RGB.
module lane_color_mapper
    import lane_color_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int COLOR_W      = 8,
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_SHIFT  = 4,
    parameter int GRAD_SHIFT   = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 pixel_valid,
    input  logic                 frame_start,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic                 is_ball,
    input  logic                 is_background,
    input  logic                 is_receptor_background,
    input  logic [NUM_LANES-1:0] is_receptor,
    input  logic [NUM_LANES-1:0] display_arrow,
    input  logic [NUM_LANES-1:0] hit_pulse,
    output logic [COLOR_W-1:0]   VGA_R,
    output logic [COLOR_W-1:0]   VGA_G,
    output logic [COLOR_W-1:0]   VGA_B,
    output logic                 vga_valid
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SUM_W  = COLOR_W + FLASH_SHIFT + 5;
    localparam int GW     = ((COLOR_W > 10) ? COLOR_W : 10) + 1;
    localparam logic [COLOR_W-1:0] ONES = {COLOR_W{1'b1}};

    logic [3:0]        flash_cnt_s [NUM_LANES];

    logic              arrow_hit_s;
    logic [LANE_W-1:0] arrow_lane_s;
    logic              rcpt_hit_s;
    logic [LANE_W-1:0] rcpt_lane_s;

    layer_t            layer_d;
    layer_t            layer_q;
    logic [LANE_W-1:0] lane_d;
    logic [LANE_W-1:0] lane_q;
    logic [9:0]        drawx_q;
    logic              valid1_q;

    rgb_t              pal_s;
    logic [3:0]        cnt_s;
    logic [GW-1:0]     grad_diff_s;
    logic [COLOR_W-1:0] grad_b_s;
    logic [COLOR_W-1:0] r_d, g_d, b_d;
    logic [COLOR_W-1:0] r_q, g_q, b_q;
    logic              valid2_q;

    logic              unused_drawy;
    assign unused_drawy = ^DrawY;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_flash_timer #(
            .FLASH_FRAMES (FLASH_FRAMES)
        ) u_timer (
            .clk_i         (Clk),
            .rst_i         (Reset),
            .hit_i         (hit_pulse[i]),
            .frame_start_i (frame_start),
            .cnt_o         (flash_cnt_s[i])
        );
    end

    function automatic logic [COLOR_W-1:0] sat_boost(input logic [COLOR_W-1:0] base,
                                                     input logic [3:0] cnt);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + (SUM_W'(cnt) << FLASH_SHIFT);
        if (sum > SUM_W'(ONES)) begin
            return ONES;
        end else begin
            return sum[COLOR_W-1:0];
        end
    endfunction

    // Lowest-index lane wins for both arrows and receptors.
    always_comb begin
        arrow_hit_s  = 1'b0;
        arrow_lane_s = '0;
        rcpt_hit_s   = 1'b0;
        rcpt_lane_s  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!arrow_hit_s && display_arrow[i]) begin
                arrow_hit_s  = 1'b1;
                arrow_lane_s = LANE_W'(i);
            end else begin
                arrow_hit_s  = arrow_hit_s;
            end
            if (!rcpt_hit_s && is_receptor[i]) begin
                rcpt_hit_s  = 1'b1;
                rcpt_lane_s = LANE_W'(i);
            end else begin
                rcpt_hit_s  = rcpt_hit_s;
            end
        end
    end

    // Layer priority decode.
    always_comb begin
        layer_d = L_GRAD;
        lane_d  = '0;
        if (is_ball) begin
            layer_d = L_BALL;
        end else if (arrow_hit_s) begin
            layer_d = L_ARROW;
            lane_d  = arrow_lane_s;
        end else if (rcpt_hit_s) begin
            layer_d = L_RECEPTOR;
            lane_d  = rcpt_lane_s;
        end else if (is_receptor_background) begin
            layer_d = L_RBG;
        end else if (is_background) begin
            layer_d = L_BG;
        end else begin
            layer_d = L_GRAD;
        end
    end

    // Stage 1: decoded layer, lane and X position.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            layer_q  <= L_GRAD;
            lane_q   <= '0;
            drawx_q  <= 10'd0;
            valid1_q <= 1'b0;
        end else begin
            layer_q  <= layer_d;
            lane_q   <= lane_d;
            drawx_q  <= DrawX;
            valid1_q <= pixel_valid;
        end
    end

    // Colour selection; the flash uses the counter value live during stage 2.
    always_comb begin
        pal_s       = LANE_PAL[2'(lane_q)];
        cnt_s       = flash_cnt_s[lane_q];
        grad_diff_s = GW'(GRAD_BASE.b) - GW'(drawx_q >> GRAD_SHIFT);
        grad_b_s    = grad_diff_s[GW-1] ? {COLOR_W{1'b0}} : grad_diff_s[COLOR_W-1:0];
        r_d         = {COLOR_W{1'b0}};
        g_d         = {COLOR_W{1'b0}};
        b_d         = {COLOR_W{1'b0}};
        case (layer_q)
            L_BALL: begin
                r_d = ONES;
                g_d = ONES;
                b_d = ONES;
            end
            L_ARROW: begin
                r_d = COLOR_W'(pal_s.r);
                g_d = COLOR_W'(pal_s.g);
                b_d = COLOR_W'(pal_s.b);
            end
            L_RECEPTOR: begin
                r_d = sat_boost(COLOR_W'(pal_s.r), cnt_s);
                g_d = sat_boost(COLOR_W'(pal_s.g), cnt_s);
                b_d = sat_boost(COLOR_W'(pal_s.b), cnt_s);
            end
            L_RBG: begin
                r_d = COLOR_W'(RBG_GRAY);
                g_d = COLOR_W'(RBG_GRAY);
                b_d = COLOR_W'(RBG_GRAY);
            end
            L_BG: begin
                r_d = {COLOR_W{1'b0}};
                g_d = {COLOR_W{1'b0}};
                b_d = {COLOR_W{1'b0}};
            end
            L_GRAD: begin
                r_d = COLOR_W'(GRAD_BASE.r);
                g_d = COLOR_W'(GRAD_BASE.g);
                b_d = grad_b_s;
            end
            default: begin
                r_d = {COLOR_W{1'b0}};
                g_d = {COLOR_W{1'b0}};
                b_d = {COLOR_W{1'b0}};
            end
        endcase
    end

    // Stage 2: registered RGB and aligned valid.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q      <= {COLOR_W{1'b0}};
            g_q      <= {COLOR_W{1'b0}};
            b_q      <= {COLOR_W{1'b0}};
            valid2_q <= 1'b0;
        end else begin
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            valid2_q <= valid1_q;
        end
    end

    assign VGA_R     = r_q;
    assign VGA_G     = g_q;
    assign VGA_B     = b_q;
    assign vga_valid = valid2_q;

endmodule

// File: tb/tb_lane_color_mapper.sv
// Randomised and directed bench for lane_color_mapper against a behavioural colour model.
module tb_lane_color_mapper;

    localparam int NL = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          pixel_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [9:0]    DrawX = 10'd0;
    logic [9:0]    DrawY = 10'd0;
    logic          is_ball = 1'b0;
    logic          is_background = 1'b0;
    logic          is_receptor_background = 1'b0;
    logic [NL-1:0] is_receptor = '0;
    logic [NL-1:0] display_arrow = '0;
    logic [NL-1:0] hit_pulse = '0;
    logic [7:0]    VGA_R, VGA_G, VGA_B;
    logic          vga_valid;

    lane_color_mapper dut (
        .Clk                    (Clk),
        .Reset                  (Reset),
        .pixel_valid            (pixel_valid),
        .frame_start            (frame_start),
        .DrawX                  (DrawX),
        .DrawY                  (DrawY),
        .is_ball                (is_ball),
        .is_background          (is_background),
        .is_receptor_background (is_receptor_background),
        .is_receptor            (is_receptor),
        .display_arrow          (display_arrow),
        .hit_pulse              (hit_pulse),
        .VGA_R                  (VGA_R),
        .VGA_G                  (VGA_G),
        .VGA_B                  (VGA_B),
        .vga_valid              (vga_valid)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    int pal_r [4] = '{85, 0, 0, 170};
    int pal_g [4] = '{0, 0, 170, 170};
    int pal_b [4] = '{0, 170, 0, 0};

    int          m_cnt [NL] = '{0, 0, 0, 0};
    logic [23:0] m_nxt = 24'd0;
    logic [23:0] m_cur = 24'd0;
    bit          m_nxt_v = 1'b0;
    bit          m_cur_v = 1'b0;

    bit          lit_req = 1'b0;
    bit          lit_rgb = 1'b0;
    bit          lit_v = 1'b0;
    logic [23:0] lit_exp = 24'd0;
    string       lit_name = "";

    function automatic int lowest(input logic [NL-1:0] v);
        for (int i = 0; i < NL; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic int clamp255(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // Colour the current inputs should produce, given the model's flash counters.
    function automatic logic [23:0] ref_color();
        int r, g, b, lane, boost;
        if (is_ball) begin
            r = 255; g = 255; b = 255;
        end else if (display_arrow != '0) begin
            lane = lowest(display_arrow);
            r = pal_r[lane % 4]; g = pal_g[lane % 4]; b = pal_b[lane % 4];
        end else if (is_receptor != '0) begin
            lane  = lowest(is_receptor);
            boost = m_cnt[lane] * 16;
            r = clamp255(pal_r[lane % 4] + boost);
            g = clamp255(pal_g[lane % 4] + boost);
            b = clamp255(pal_b[lane % 4] + boost);
        end else if (is_receptor_background) begin
            r = 85; g = 85; b = 85;
        end else if (is_background) begin
            r = 0; g = 0; b = 0;
        end else begin
            r = 5; g = 75; b = 127 - int'(DrawX) / 8;
            if (b < 0) b = 0;
        end
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Reference model: flash frames counted per lane, colour appears two edges after its pixel.
    initial begin
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                for (int i = 0; i < NL; i++) m_cnt[i] = 0;
                m_cur_v = 1'b0;
                m_nxt_v = 1'b0;
            end else begin
                for (int i = 0; i < NL; i++) begin
                    if (hit_pulse[i]) m_cnt[i] = 8;
                    else if (frame_start && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                end
                m_cur   = m_nxt;
                m_cur_v = m_nxt_v;
                m_nxt   = ref_color();
                m_nxt_v = pixel_valid;
            end
        end
    end

    // Single compare process: model every cycle plus literal checks when requested.
    initial begin
        forever begin
            @(negedge Clk);
            total++;
            if (vga_valid !== m_cur_v) begin
                bad++;
                $display("FAIL valid_model: got %b want %b at %0t", vga_valid, m_cur_v, $time);
            end
            if (!Reset && m_cur_v) begin
                total++;
                if ({VGA_R, VGA_G, VGA_B} !== m_cur) begin
                    bad++;
                    $display("FAIL rgb_model: got %h want %h at %0t", {VGA_R, VGA_G, VGA_B}, m_cur, $time);
                end
            end
            if (lit_req) begin
                total++;
                if (vga_valid !== lit_v) begin
                    bad++;
                    $display("FAIL %s valid: got %b want %b", lit_name, vga_valid, lit_v);
                end
                if (lit_rgb) begin
                    total++;
                    if ({VGA_R, VGA_G, VGA_B} !== lit_exp) begin
                        bad++;
                        $display("FAIL %s rgb: got %h want %h", lit_name, {VGA_R, VGA_G, VGA_B}, lit_exp);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic lit(input string name, input bit chk_rgb, input logic [23:0] exp_rgb, input bit exp_v);
        lit_name = name;
        lit_rgb  = chk_rgb;
        lit_exp  = exp_rgb;
        lit_v    = exp_v;
        lit_req  = 1'b1;
        @(negedge Clk);
        #1;
        lit_req  = 1'b0;
    endtask

    initial begin
        step(3);
        lit("reset_state", 1'b1, 24'h000000, 1'b0);
        Reset = 1'b0;
        pixel_valid = 1'b1;
        DrawX = 10'd0;
        step(1);
        lit("latency_1", 1'b0, 24'h000000, 1'b0);
        step(1);
        lit("grad_x0", 1'b1, 24'h054B7F, 1'b1);
        DrawX = 10'd1023;
        step(2);
        lit("grad_clamp", 1'b1, 24'h054B00, 1'b1);
        DrawX = 10'd100;
        step(2);
        lit("grad_x100", 1'b1, 24'h054B73, 1'b1);

        is_ball = 1'b1; display_arrow = 4'b1111;
        step(2);
        lit("ball_over_arrow", 1'b1, 24'hFFFFFF, 1'b1);
        is_ball = 1'b0; display_arrow = 4'b0110;
        step(2);
        lit("arrow_lane1", 1'b1, 24'h0000AA, 1'b1);

        display_arrow = 4'b0000; is_receptor = 4'b0001;
        step(2);
        lit("rcpt0_idle", 1'b1, 24'h550000, 1'b1);
        hit_pulse = 4'b0001;
        step(1);
        hit_pulse = 4'b0000;
        step(1);
        lit("rcpt0_flash8", 1'b1, 24'hD58080, 1'b1);
        frame_start = 1'b1;
        step(3);
        frame_start = 1'b0;
        step(1);
        lit("rcpt0_flash5", 1'b1, 24'hA55050, 1'b1);
        frame_start = 1'b1;
        step(5);
        frame_start = 1'b0;
        step(1);
        lit("rcpt0_flash0", 1'b1, 24'h550000, 1'b1);

        is_receptor = 4'b0100; hit_pulse = 4'b0100; frame_start = 1'b1;
        step(1);
        hit_pulse = 4'b0000; frame_start = 1'b0;
        step(1);
        lit("load_beats_dec", 1'b1, 24'h80FF80, 1'b1);
        frame_start = 1'b1;
        step(9);
        frame_start = 1'b0;
        step(1);
        lit("zero_stays_zero", 1'b1, 24'h00AA00, 1'b1);

        is_receptor = 4'b1000; hit_pulse = 4'b1000;
        step(1);
        hit_pulse = 4'b0000;
        step(1);
        lit("saturate_lane3", 1'b1, 24'hFFFF80, 1'b1);
        display_arrow = 4'b1000;
        step(2);
        lit("arrow_no_flash", 1'b1, 24'hAAAA00, 1'b1);

        display_arrow = 4'b0000; is_receptor = 4'b0001; hit_pulse = 4'b0001;
        step(1);
        hit_pulse = 4'b0000;
        Reset = 1'b1;
        lit("reset_mid", 1'b1, 24'h000000, 1'b0);
        step(2);
        Reset = 1'b0;
        step(1);
        lit("post_reset_lat1", 1'b0, 24'h000000, 1'b0);
        step(1);
        lit("post_reset_noflash", 1'b1, 24'h550000, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            pixel_valid            = ($urandom_range(0, 9) != 0);
            frame_start            = ($urandom_range(0, 19) == 0);
            DrawX                  = 10'($urandom_range(0, 1023));
            DrawY                  = 10'($urandom_range(0, 1023));
            is_ball                = ($urandom_range(0, 15) == 0);
            is_background          = 1'($urandom_range(0, 1));
            is_receptor_background = 1'($urandom_range(0, 1));
            display_arrow          = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            is_receptor            = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            for (int i = 0; i < NL; i++) hit_pulse[i] = ($urandom_range(0, 15) == 0);
            Reset                  = ($urandom_range(0, 499) == 0);
            step(1);
        end
        Reset = 1'b0;
        hit_pulse = 4'b0000;
        frame_start = 1'b0;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
